// File: rtl/nios2_gen2_debug_scan_master.sv
// nios2_gen2_debug_scan_master
//
// Host-side scan sequencer for the virtual-JTAG port of the Nios II debug slave.
// Each accepted command runs one full transaction on a divided TCK: an optional
// IR update, capture-DR, a DR_WIDTH-bit shift and update-DR. The captured DR
// and the slave IR status are then returned with a one-cycle rsp_valid pulse.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; ready only while idle
//   cmd_ir, cmd_skip_ir    IR to load; skip keeps the previous ir_in, no UIR phase
//   cmd_dr                 DR data shifted out on vji_tdi, LSB first
//   rsp_valid              one-cycle completion pulse
//   rsp_dr, rsp_ir         captured tdo bits (bit 0 first) and vji_ir_out from UDR
//   vji_*                  virtual-JTAG master side: tck, tdi/tdo, ir_in/ir_out,
//                          uir/cdr/sdr/udr strobes and rti
module nios2_gen2_debug_scan_master #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned IR_WIDTH = 2,
    parameter int unsigned TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic                cmd_skip_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int unsigned DivW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int unsigned BitW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(TCK_DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DR_WIDTH - 1);

    // One-hot so every strobe and handshake output is a state flop bit.
    typedef enum logic [5:0] {
        StIdle = 6'b000001,
        StUir  = 6'b000010,
        StCdr  = 6'b000100,
        StSdr  = 6'b001000,
        StUdr  = 6'b010000,
        StDone = 6'b100000
    } state_e;

    state_e              state_q;
    logic [DivW-1:0]     div_q;
    logic                tck_q;
    logic [BitW-1:0]     bit_q;
    logic                tdi_q;
    logic [DR_WIDTH-1:0] shift_q;
    logic [DR_WIDTH-1:0] cap_q;
    logic [IR_WIDTH-1:0] ir_in_q;
    logic [IR_WIDTH-1:0] ir_cap_q;
    logic [DR_WIDTH-1:0] rsp_dr_q;
    logic [IR_WIDTH-1:0] rsp_ir_q;

    logic half_end;
    logic tck_rise;
    logic period_end;

    assign half_end   = (div_q == DivLast);
    assign tck_rise   = half_end && !tck_q;
    assign period_end = half_end && tck_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            div_q    <= '0;
            tck_q    <= 1'b0;
            bit_q    <= '0;
            tdi_q    <= 1'b0;
            shift_q  <= '0;
            cap_q    <= '0;
            ir_in_q  <= '0;
            ir_cap_q <= '0;
            rsp_dr_q <= '0;
            rsp_ir_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        shift_q <= cmd_dr;
                        if (!cmd_skip_ir) begin
                            ir_in_q <= cmd_ir;
                        end
                        state_q <= cmd_skip_ir ? StCdr : StUir;
                        div_q   <= '0;
                        tck_q   <= 1'b0;
                        bit_q   <= '0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    // Active phases: TCK low for TCK_DIV clks, then high for TCK_DIV clks.
                    if (half_end) begin
                        div_q <= '0;
                        tck_q <= ~tck_q;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                    if (tck_rise) begin
                        if (state_q == StSdr) begin
                            cap_q <= {vji_tdo, cap_q[DR_WIDTH-1:1]};
                        end
                        if (state_q == StUdr) begin
                            ir_cap_q <= vji_ir_out;
                        end
                    end
                    // Phase changes and tdi updates land on the first clk of a TCK period.
                    if (period_end) begin
                        case (state_q)
                            StUir: state_q <= StCdr;
                            StCdr: begin
                                state_q <= StSdr;
                                tdi_q   <= shift_q[0];
                                shift_q <= shift_q >> 1;
                            end
                            StSdr: begin
                                if (bit_q == BitLast) begin
                                    state_q <= StUdr;
                                    tdi_q   <= 1'b0;
                                end else begin
                                    bit_q   <= bit_q + 1'b1;
                                    tdi_q   <= shift_q[0];
                                    shift_q <= shift_q >> 1;
                                end
                            end
                            StUdr: begin
                                state_q  <= StDone;
                                rsp_dr_q <= cap_q;
                                rsp_ir_q <= ir_cap_q;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign vji_rti   = state_q[0];
    assign cmd_ready = state_q[0];
    assign vji_uir   = state_q[1];
    assign vji_cdr   = state_q[2];
    assign vji_sdr   = state_q[3];
    assign vji_udr   = state_q[4];
    assign rsp_valid = state_q[5];
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_in_q;
    assign rsp_dr    = rsp_dr_q;
    assign rsp_ir    = rsp_ir_q;

endmodule

// File: tb/tb_nios2_gen2_debug_scan_master.sv
// Bench for nios2_gen2_debug_scan_master: a default-parameter instance driven through
// a scoreboard of expected responses, plus a TCK_DIV=1 instance for back-to-back commands.
module tb_nios2_gen2_debug_scan_master;

    localparam int DW = 38;
    localparam int LAT_FULL = 1 + (DW + 3) * 2 * 2;
    localparam int LAT_SKIP = 1 + (DW + 2) * 2 * 2;
    localparam int LAT_DIV1 = 1 + (DW + 3) * 2 * 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_ir = '0;
    logic          cmd_skip_ir = 1'b0;
    logic [DW-1:0] cmd_dr = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_dr;
    logic [1:0]    rsp_ir;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic [1:0]    vji_ir_in, vji_ir_out;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    nios2_gen2_debug_scan_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_skip_ir(cmd_skip_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .rsp_ir(rsp_ir),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    // TCK_DIV=1 instance; slave ties tdo=1 and ir_out=01
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic          b_rsp_valid;
    logic [DW-1:0] b_rsp_dr;
    logic [1:0]    b_rsp_ir;
    logic          b_tck, b_tdi;
    logic [1:0]    b_ir_in;
    logic          b_uir, b_cdr, b_sdr, b_udr, b_rti;

    nios2_gen2_debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(2), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_ir(2'b10),
        .cmd_skip_ir(1'b0), .cmd_dr({DW{1'b0}}),
        .rsp_valid(b_rsp_valid), .rsp_dr(b_rsp_dr), .rsp_ir(b_rsp_ir),
        .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(1'b1),
        .vji_ir_in(b_ir_in), .vji_ir_out(2'b01),
        .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr),
        .vji_rti(b_rti)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave model: mode 0 returns tdi one TCK period late; mode 1 drives tdo=1
    // only during the first SDR period.
    int         slave_mode = 0;
    logic       loop_tdo = 1'b0;
    int         sdr_idx = 0;
    logic [1:0] ir_out_val = 2'b00;

    initial forever begin
        @(posedge vji_tck);
        loop_tdo = vji_tdi;
        if (vji_cdr) sdr_idx = 0;
        else if (vji_sdr) sdr_idx++;
    end

    assign vji_tdo    = (slave_mode == 0) ? loop_tdo : (vji_sdr && sdr_idx == 0);
    assign vji_ir_out = vji_udr ? ir_out_val : 2'b00;

    typedef struct {
        logic [DW-1:0] dr;
        logic [1:0]    ir;
        logic [1:0]    ir_in;
        int            lat;
        int            uir;
        int            cdr;
        int            sdr;
        int            udr;
    } exp_t;

    exp_t sb[$];

    // Response monitor: counts strobe widths per transaction and pops the scoreboard.
    int acc_cyc = 0;
    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0;
    int n_hot_err = 0, n_tdi_err = 0, n_ir_err = 0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (vji_uir) n_uir++;
            if (vji_cdr) n_cdr++;
            if (vji_sdr) n_sdr++;
            if (vji_udr) n_udr++;
            if (!cmd_ready && !rsp_valid &&
                ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr}) != 1)) n_hot_err++;
            if (!vji_sdr && vji_tdi) n_tdi_err++;
            if (vji_uir && sb.size() > 0 && vji_ir_in !== sb[0].ir_in) n_ir_err++;
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
                n_hot_err = 0; n_tdi_err = 0; n_ir_err = 0;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("latency", 64'(cyc - acc_cyc), 64'(e.lat));
                    check_eq("rsp_dr", 64'(rsp_dr), 64'(e.dr));
                    check_eq("rsp_ir", 64'(rsp_ir), 64'(e.ir));
                    check_eq("ir_in", 64'(vji_ir_in), 64'(e.ir_in));
                    check_eq("uir_clks", 64'(n_uir), 64'(e.uir));
                    check_eq("cdr_clks", 64'(n_cdr), 64'(e.cdr));
                    check_eq("sdr_clks", 64'(n_sdr), 64'(e.sdr));
                    check_eq("udr_clks", 64'(n_udr), 64'(e.udr));
                    check_eq("strobe_onehot_err", 64'(n_hot_err), 64'd0);
                    check_eq("tdi_outside_sdr", 64'(n_tdi_err), 64'd0);
                    check_eq("ir_in_during_uir", 64'(n_ir_err), 64'd0);
                    check_eq("tck_low_done", 64'(vji_tck), 64'd0);
                    check_eq("ready_low_done", 64'(cmd_ready), 64'd0);
                end
            end
        end
    end

    // TCK_DIV=1 monitor
    int b_acc[$];
    int b_rsp[$];
    logic [DW-1:0] b_dr[$];

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (b_valid && b_ready) b_acc.push_back(cyc);
            if (b_rsp_valid) begin
                b_rsp.push_back(cyc);
                b_dr.push_back(b_rsp_dr);
            end
        end
    end

    task automatic send(input logic [1:0] ir, input logic skip, input logic [DW-1:0] dr,
                        input exp_t e);
        int n = 0;
        @(posedge clk); #1;
        while (!cmd_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ready_wait", 64'(cmd_ready), 64'd1);
        cmd_ir = ir;
        cmd_skip_ir = skip;
        cmd_dr = dr;
        cmd_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rsp_timeout", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [DW-1:0] rand_dr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        exp_t e;
        int n;
        int udr_seen, rsp_seen;

        // reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_tck, vji_tdi}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_rti", 64'(vji_rti), 64'd1);
        check_eq("rst_outs", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_tck, vji_tdi,
                                   rsp_valid}), 64'd0);
        check_eq("rst_rsp_dr", 64'(rsp_dr), 64'd0);
        check_eq("rst_rsp_ir", 64'(rsp_ir), 64'd0);
        check_eq("rst_ir_in", 64'(vji_ir_in), 64'd0);

        // loopback, IR 01
        slave_mode = 0;
        ir_out_val = 2'b11;
        d = 38'h2A_5A5A_5A5A;
        e = '{dr: {d[DW-2:0], 1'b0}, ir: 2'b11, ir_in: 2'b01, lat: LAT_FULL,
              uir: 4, cdr: 4, sdr: DW * 4, udr: 4};
        send(2'b01, 1'b0, d, e);
        wait_rsp();

        // IR 10, then skip with cmd_ir 11 keeps 10
        ir_out_val = 2'b01;
        d = rand_dr();
        e = '{dr: {d[DW-2:0], 1'b0}, ir: 2'b01, ir_in: 2'b10, lat: LAT_FULL,
              uir: 4, cdr: 4, sdr: DW * 4, udr: 4};
        send(2'b10, 1'b0, d, e);
        wait_rsp();
        d = rand_dr();
        e = '{dr: {d[DW-2:0], 1'b0}, ir: 2'b01, ir_in: 2'b10, lat: LAT_SKIP,
              uir: 0, cdr: 4, sdr: DW * 4, udr: 4};
        send(2'b11, 1'b1, d, e);
        wait_rsp();

        // capture ordering
        slave_mode = 1;
        ir_out_val = 2'b10;
        d = rand_dr();
        e = '{dr: 38'h1, ir: 2'b10, ir_in: 2'b01, lat: LAT_FULL,
              uir: 4, cdr: 4, sdr: DW * 4, udr: 4};
        send(2'b01, 1'b0, d, e);
        wait_rsp();
        check_eq("rsp_dr_hold", 64'(rsp_dr), 64'h1);

        // reset mid-SDR
        slave_mode = 0;
        d = rand_dr();
        e = '{dr: {d[DW-2:0], 1'b0}, ir: 2'b10, ir_in: 2'b11, lat: LAT_FULL,
              uir: 4, cdr: 4, sdr: DW * 4, udr: 4};
        send(2'b11, 1'b0, d, e);
        n = 0;
        while (cyc < acc_cyc + 60 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("sdr_at_60", 64'(vji_sdr), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        check_eq("midrst_ready", 64'(cmd_ready), 64'd1);
        check_eq("midrst_outs", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_tck, vji_tdi,
                                      rsp_valid}), 64'd0);
        check_eq("midrst_ir_in", 64'(vji_ir_in), 64'd0);
        udr_seen = 0;
        rsp_seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (vji_udr) udr_seen++;
            if (rsp_valid) rsp_seen++;
        end
        check_eq("midrst_no_udr", 64'(udr_seen), 64'd0);
        check_eq("midrst_no_rsp", 64'(rsp_seen), 64'd0);
        d = rand_dr();
        e = '{dr: {d[DW-2:0], 1'b0}, ir: 2'b10, ir_in: 2'b01, lat: LAT_FULL,
              uir: 4, cdr: 4, sdr: DW * 4, udr: 4};
        send(2'b01, 1'b0, d, e);
        wait_rsp();

        // back-to-back on the TCK_DIV=1 instance, cmd_valid held high
        @(posedge clk); #1;
        b_valid = 1'b1;
        n = 0;
        while (b_acc.size() < 2 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        b_valid = 1'b0;
        n = 0;
        while (b_rsp.size() < 2 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("b2b_accepts", 64'(b_acc.size()), 64'd2);
        check_eq("b2b_rsps", 64'(b_rsp.size()), 64'd2);
        if (b_acc.size() == 2 && b_rsp.size() == 2) begin
            check_eq("b2b_lat1", 64'(b_rsp[0] - b_acc[0]), 64'(LAT_DIV1));
            check_eq("b2b_accept_gap", 64'(b_acc[1] - b_rsp[0]), 64'd1);
            check_eq("b2b_lat2", 64'(b_rsp[1] - b_acc[1]), 64'(LAT_DIV1));
            check_eq("b2b_dr0", 64'(b_dr[0]), 64'({DW{1'b1}}));
            check_eq("b2b_dr1", 64'(b_dr[1]), 64'({DW{1'b1}}));
            check_eq("b2b_ir", 64'(b_rsp_ir), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
